// File: rtl/id_front_if.sv
// Decode-front bus: fetch-side inputs, write-back port, and decoded/branch outputs.
interface id_front_if;
  logic        freez;
  logic [31:0] pc_in;
  logic [31:0] instruction_in;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_value;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic [4:0]  dest;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [31:0] imm;
  logic        br_taken;
  logic [31:0] br_offset;

  modport master (
    output freez, pc_in, instruction_in, wb_en, wb_dest, wb_value,
    input  pc_out, instruction_out, src1, src2, dest, val1, val2, imm,
           br_taken, br_offset
  );

  modport slave (
    input  freez, pc_in, instruction_in, wb_en, wb_dest, wb_value,
    output pc_out, instruction_out, src1, src2, dest, val1, val2, imm,
           br_taken, br_offset
  );
endinterface

// File: rtl/id_front.sv
// Decode front: IF/ID register, bypassed 32x32 register file, and branch
// resolution feeding the redirect back to fetch.
module id_front #(
  parameter logic [31:0] NOP_WORD = 32'd0,
  parameter logic [5:0]  OP_BEZ   = 6'd40,
  parameter logic [5:0]  OP_BNE   = 6'd41,
  parameter logic [5:0]  OP_JMP   = 6'd42
) (
  input logic        clk,
  input logic        rst,
  id_front_if.slave  bus
);

  logic [31:0] pc_q, ins_q;
  logic [31:0] rf [32];
  logic [5:0]  op;
  logic [4:0]  s1, s2;
  logic [31:0] v1, v2;
  logic        raw, br;

  // A taken branch flushes its own slot so the redirect costs one bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      ins_q <= NOP_WORD;
    end else if (br) begin
      pc_q  <= '0;
      ins_q <= NOP_WORD;
    end else if (!bus.freez) begin
      pc_q  <= bus.pc_in;
      ins_q <= bus.instruction_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.wb_en && bus.wb_dest != 5'd0) begin
      rf[bus.wb_dest] <= bus.wb_value;
    end
  end

  assign op = ins_q[31:26];
  assign s1 = ins_q[25:21];
  assign s2 = ins_q[20:16];

  // Same-cycle write-back is forwarded so decode never sees a stale operand.
  assign v1 = (s1 == 5'd0) ? '0 :
              (bus.wb_en && bus.wb_dest == s1) ? bus.wb_value : rf[s1];
  assign v2 = (s2 == 5'd0) ? '0 :
              (bus.wb_en && bus.wb_dest == s2) ? bus.wb_value : rf[s2];

  assign raw = (op == OP_JMP) ||
               (op == OP_BEZ && v1 == 32'd0) ||
               (op == OP_BNE && v1 != v2);
  assign br  = raw & ~bus.freez & ~rst;

  assign bus.pc_out          = pc_q;
  assign bus.instruction_out = ins_q;
  assign bus.src1            = s1;
  assign bus.src2            = s2;
  assign bus.dest            = op[5] ? ins_q[20:16] : ins_q[15:11];
  assign bus.val1            = v1;
  assign bus.val2            = v2;
  assign bus.imm             = {{16{ins_q[15]}}, ins_q[15:0]};
  assign bus.br_taken        = br;
  assign bus.br_offset       = {{16{ins_q[15]}}, ins_q[15:0]};

endmodule

// File: tb/tb_id_front.sv
// Bench for id_front: directed cases from the test plan, then random traffic
// checked each cycle against a behavioural model of the decode front.
module tb_id_front;
  localparam logic [5:0]  BEZ = 6'd40;
  localparam logic [5:0]  BNE = 6'd41;
  localparam logic [5:0]  JMP = 6'd42;
  localparam logic [31:0] NOP = 32'd0;

  logic clk = 1'b0;
  logic rst;
  id_front_if bus();

  id_front #(.NOP_WORD(NOP), .OP_BEZ(BEZ), .OP_BNE(BNE), .OP_JMP(JMP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_pc, m_ins;
  logic [31:0] m_rf [32];
  bit          m_valid = 0;
  logic        br_now;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_val(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.wb_en && bus.wb_dest == a) return bus.wb_value;
    return m_rf[a];
  endfunction

  function automatic logic m_br();
    logic [5:0]  op;
    logic [31:0] a, b;
    op = m_ins[31:26];
    a  = m_val(m_ins[25:21]);
    b  = m_val(m_ins[20:16]);
    if (rst || bus.freez) return 1'b0;
    return (op == JMP) || (op == BEZ && a == 0) || (op == BNE && a != b);
  endfunction

  function automatic logic [31:0] m_imm();
    int s;
    s = $signed(m_ins[15:0]);
    return s;
  endfunction

  // Model state advance
  always @(posedge clk) begin
    br_now = m_br();
    if (rst) begin
      m_valid = 1;
      m_pc    = 32'd0;
      m_ins   = NOP;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else begin
      if (bus.wb_en && bus.wb_dest != 0) m_rf[bus.wb_dest] = bus.wb_value;
      if (br_now) begin
        m_pc  = 32'd0;
        m_ins = NOP;
      end else if (!bus.freez) begin
        m_pc  = bus.pc_in;
        m_ins = bus.instruction_in;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("pc_out", bus.pc_out, m_pc);
      chk("instruction_out", bus.instruction_out, m_ins);
      chk("src1", {27'd0, bus.src1}, {27'd0, m_ins[25:21]});
      chk("src2", {27'd0, bus.src2}, {27'd0, m_ins[20:16]});
      chk("dest", {27'd0, bus.dest},
          {27'd0, (m_ins[31:26] < 32) ? m_ins[15:11] : m_ins[20:16]});
      chk("val1", bus.val1, m_val(m_ins[25:21]));
      chk("val2", bus.val2, m_val(m_ins[20:16]));
      chk("imm", bus.imm, m_imm());
      chk("br_taken", {31'd0, bus.br_taken}, {31'd0, m_br()});
      chk("br_offset", bus.br_offset, m_imm());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    bus.wb_en = 1'b1; bus.wb_dest = r; bus.wb_value = v;
    tick();
    bus.wb_en = 1'b0;
  endtask

  task automatic ld(input logic [31:0] w);
    bus.instruction_in = w;
    bus.pc_in = $urandom;
    tick();
  endtask

  initial begin
    logic [31:0] w, jw, bne;
    logic [4:0]  a, b;
    rst = 1'b1;
    bus.freez = 1'b0; bus.pc_in = 32'h1000; bus.instruction_in = 32'hFFFF_FFFF;
    bus.wb_en = 1'b0; bus.wb_dest = 5'd0; bus.wb_value = 32'd0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst pc_out", bus.pc_out, 32'd0);
    chk("rst instruction_out", bus.instruction_out, 32'd0);
    chk("rst br_taken", {31'd0, bus.br_taken}, 32'd0);
    rst = 1'b0; bus.instruction_in = 32'd0;

    // every register reads zero after reset
    for (int i = 0; i < 32; i++) begin
      a = i[4:0];
      b = 5'(31 - i);
      ld({6'd0, a, b, 16'd0});
      @(negedge clk);
      chk("rst val1", bus.val1, 32'd0);
      chk("rst val2", bus.val2, 32'd0);
    end

    // write-through bypass on r5
    ld({6'd0, 5'd5, 5'd0, 16'd0});
    bus.wb_en = 1'b1; bus.wb_dest = 5'd5; bus.wb_value = 32'h1234;
    @(negedge clk);
    chk("bypass val1", bus.val1, 32'h1234);
    tick();
    bus.wb_en = 1'b0;
    @(negedge clk);
    chk("stored val1", bus.val1, 32'h1234);

    // r0 ignores writes and bypass
    ld({6'd0, 5'd0, 5'd0, 16'd0});
    bus.wb_en = 1'b1; bus.wb_dest = 5'd0; bus.wb_value = 32'hDEAD;
    @(negedge clk);
    chk("r0 bypass", bus.val1, 32'd0);
    tick();
    bus.wb_en = 1'b0;
    @(negedge clk);
    chk("r0 read", bus.val1, 32'd0);

    // BEZ taken, then flush; then not taken
    wr(5'd3, 32'd0);
    ld({BEZ, 5'd3, 5'd0, 16'hFFFE});
    bus.instruction_in = 32'd0;
    @(negedge clk);
    chk("bez br_taken", {31'd0, bus.br_taken}, 32'd1);
    chk("bez br_offset", bus.br_offset, 32'hFFFF_FFFE);
    tick();
    @(negedge clk);
    chk("bez flush ins", bus.instruction_out, NOP);
    chk("bez flush pc", bus.pc_out, 32'd0);
    wr(5'd3, 32'd7);
    ld({BEZ, 5'd3, 5'd0, 16'hFFFE});
    bus.instruction_in = 32'd0;
    @(negedge clk);
    chk("bez r3=7 br_taken", {31'd0, bus.br_taken}, 32'd0);
    tick();

    // BNE held by freeze, then released
    wr(5'd1, 32'd1);
    wr(5'd2, 32'd2);
    bne = {BNE, 5'd1, 5'd2, 16'h0010};
    ld(bne);
    bus.freez = 1'b1;
    bus.instruction_in = 32'h0400_0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bne frz br_taken", {31'd0, bus.br_taken}, 32'd0);
      chk("bne frz hold", bus.instruction_out, bne);
      tick();
    end
    bus.freez = 1'b0;
    @(negedge clk);
    chk("bne release br_taken", {31'd0, bus.br_taken}, 32'd1);
    tick();
    @(negedge clk);
    chk("bne flush ins", bus.instruction_out, NOP);

    // dest selection by opcode class
    ld({6'd1, 5'd2, 5'd7, 5'd9, 11'd0});
    @(negedge clk);
    chk("dest op1", {27'd0, bus.dest}, 32'd9);
    ld({6'd33, 5'd2, 5'd4, 5'd12, 11'd0});
    @(negedge clk);
    chk("dest op33", {27'd0, bus.dest}, 32'd4);

    // JMP under freeze: no redirect, no flush
    jw = {JMP, 26'h0000123};
    ld(jw);
    bus.freez = 1'b1;
    bus.instruction_in = 32'd0;
    @(negedge clk);
    chk("jmp frz br_taken", {31'd0, bus.br_taken}, 32'd0);
    tick();
    @(negedge clk);
    chk("jmp frz hold", bus.instruction_out, jw);
    bus.freez = 1'b0;
    tick();
    @(negedge clk);
    chk("jmp flush ins", bus.instruction_out, NOP);

    // reset over a pending jump
    ld(jw);
    rst = 1'b1;
    @(negedge clk);
    chk("rst jmp br_taken", {31'd0, bus.br_taken}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst jmp ins", bus.instruction_out, NOP);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      bus.freez = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 5))
        0: w[31:26] = BEZ;
        1: w[31:26] = BNE;
        2: w[31:26] = JMP;
        3: w[31:26] = 6'($urandom);
        default: w[31:26] = 6'($urandom_range(0, 3));
      endcase
      w[25:21] = 5'($urandom_range(0, 7));
      w[20:16] = 5'($urandom_range(0, 7));
      w[15:0]  = 16'($urandom);
      bus.instruction_in = w;
      bus.pc_in    = $urandom;
      bus.wb_en    = 1'($urandom);
      bus.wb_dest  = 5'($urandom_range(0, 7));
      bus.wb_value = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      tick();
    end
    rst = 1'b0; bus.freez = 1'b0; bus.wb_en = 1'b0;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/id_front.md
# id_front

Front half of the decode stage, directly downstream of the fetch stage. It consumes the fetched `pc` and `instruction` through an internal IF/ID pipeline register, holding or flushing it as required. It reads operands from a 32×32 register file that has a write-back port and same-cycle bypass. It resolves branches in decode and returns `br_taken` and `br_offset` to the fetch stage.

## Interface
- `NOP_WORD`, default 32'd0: instruction word loaded on flush or reset.
- `OP_BEZ`, default 6'd40: branch-if-zero opcode.
- `OP_BNE`, default 6'd41: branch-if-not-equal opcode.
- `OP_JMP`, default 6'd42: unconditional jump opcode.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `freez` in 1: hazard stall. Holds IF/ID; suppresses `br_taken`.
- `pc_in` in 32: fetch-stage `pc` output.
- `instruction_in` in 32: fetch-stage `instruction` output.
- `wb_en` in 1: register-file write enable.
- `wb_dest` in 5: write address.
- `wb_value` in 32: write data.
- `pc_out` out 32: IF/ID pc.
- `instruction_out` out 32: IF/ID instruction.
- `src1`, `src2`, `dest` out 5 each: decoded register addresses.
- `val1`, `val2` out 32 each: bypassed operand values.
- `imm` out 32: sign-extended `instruction_out[15:0]`.
- `br_taken` out 1: to fetch stage.
- `br_offset` out 32: to fetch stage; equals `imm`.

## Operation
**IF/ID register**
- Priority on each rising edge: `rst` > `br_taken` (flush) > `freez` (hold) > load.
- Reset and flush both load `pc_out`=0 and `instruction_out`=`NOP_WORD`.
- Load: `pc_out`←`pc_in`, `instruction_out`←`instruction_in`.

**Field decode** (combinational from `instruction_out`)
- `op`=[31:26], `src1`=[25:21], `src2`=[20:16].
- `dest` = [15:11] when `op`<32, else [20:16].

**Register file**
- 32 entries × 32 bits. Reset clears all entries to 0.
- Write on rising edge when `wb_en` and `wb_dest`≠0.
- Register 0 always reads 0, and writes to it are ignored.
- Read ports are combinational with write-through bypass: if `wb_en` and `wb_dest`==`srcN` and `srcN`≠0, `valN`=`wb_value`.

**Branch resolution**
- `raw` is true when any of:
  - `op`==`OP_JMP`
  - `op`==`OP_BEZ` and `val1`==0
  - `op`==`OP_BNE` and `val1`≠`val2`
- `br_taken` = `raw` & ~`freez` & ~`rst`.
- `br_offset` = `imm` (word offset). The fetch stage performs the shift and the −4 correction.

## Timing
- Latency: the fetch outputs sampled at edge N appear on `pc_out`/`instruction_out` after edge N.
- `br_taken` is asserted in the same cycle the branch sits in IF/ID. At the next edge IF/ID is flushed and the fetch pc redirects, so there is exactly one bubble.
- Back-to-back branches: the flushed NOP never branches.
- `freez` and a taken-condition together: no flush and no redirect. The branch re-evaluates each cycle until `freez` drops.
- Reset mid-operation: the IF/ID register and all registers clear at that edge. `br_taken`=0 while `rst`=1.
- Write-back to register R at edge N: a read of R in cycle N sees `wb_value` via the bypass. After the edge it sees the stored value.
- Register-file writes continue during `freez` and during flush.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `instruction_in`=32'hFFFFFFFF. Expect `instruction_out`=0, `pc_out`=0, `br_taken`=0, and `val1`/`val2`=0 for all addresses.
- **Bypass and r0:**
  - Set `wb_en`=1, `wb_dest`=5, `wb_value`=32'h1234, with IF/ID holding `src1`=5. Expect `val1`=32'h1234 in that same cycle.
  - Write 32'hDEAD to r0, then read r0. Expect 0.
- **BEZ:** load BEZ with `src1`=3, r3=0, imm=16'hFFFE.
  - Expect `br_taken`=1 and `br_offset`=32'hFFFFFFFE.
  - At the next edge, `instruction_out`=`NOP_WORD`.
  - Repeat with r3=7. Expect `br_taken`=0.
- **BNE with freeze:** r1=1, r2=2, `freez`=1 for 3 cycles. Expect `br_taken`=0 and IF/ID unchanged. When `freez` drops, expect `br_taken`=1, followed by a flush.
- **Dest select:** for `op`=1 with [15:11]=9, expect `dest`=9. For `op`=33 with [20:16]=4, expect `dest`=4.
- **Simultaneous flush and freeze:** JMP in IF/ID with `freez`=1. Expect no flush and `br_taken`=0.
